// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;

  localparam int WORD_BYTES  = 4;
  localparam int DMEM_WAIT_W = 4;

  // One accepted CPU data-port request, held for the duration of the wait states.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Word address lies inside a DEPTH-word array.
  function automatic logic in_range(input logic [31:0] a, input int depth);
    return {2'b00, a[31:2]} < 32'(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, registered read with clear-on-read.
import dmem_pkg::*;

module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic          rclr,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rclr returns zero instead of array data (rejected loads).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= rclr ? '0 : mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target with req/ready handshake and WAIT_STATES programmable latency.
// Optional DMEM_BOUNDS_CHECK_EN: out-of-range words flag err and are not accessed.
import dmem_pkg::*;

module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t            state;
  logic [DMEM_WAIT_W-1:0] cnt;
  dmem_req_t              lat, inc, cur;
  logic                   accept, fin, oob;
  logic [AW-1:0]          idx;
  logic                   unused_addr;

  assign inc    = '{write: memWrite, addr: addr, wdata: writeData};
  assign accept = req && (state == IDLE || state == DONE);

  // With zero wait states the access completes on the accepting edge,
  // so it must use the live request rather than the latch.
  assign fin = (state == BUSY && cnt == '0) || (accept && WAIT_STATES == 0);
  assign cur = (WAIT_STATES == 0) ? inc : lat;
  assign idx = cur.addr[2 +: AW];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = !in_range(cur.addr, DEPTH);
`else
  assign oob = 1'b0;
`endif

  assign unused_addr = ^cur.addr;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (fin && cur.write && !oob),
    .waddr (idx),
    .wdata (cur.wdata),
    .re    (fin && !cur.write),
    .rclr  (oob),
    .raddr (idx),
    .rdata (readData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      lat   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      ready <= fin;
      err   <= fin && oob;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            lat <= inc;
            if (WAIT_STATES == 0) begin
              state <= DONE;
            end else begin
              cnt   <= DMEM_WAIT_W'(WAIT_STATES - 1);
              state <= BUSY;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with 2 wait states, one with none, shared clock/reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        a_req = 0, a_we = 0;
  logic [31:0] a_addr = '0, a_wd = '0, a_rd;
  logic        a_ready, a_err;

  logic        z_req = 0, z_we = 0;
  logic [31:0] z_addr = '0, z_wd = '0, z_rd;
  logic        z_ready, z_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_STATES(2)) u_a (
    .clk(clk), .reset(reset), .req(a_req), .memWrite(a_we), .addr(a_addr),
    .writeData(a_wd), .readData(a_rd), .ready(a_ready), .err(a_err)
  );

  dmem_responder #(.DEPTH(64), .WAIT_STATES(0)) u_z (
    .clk(clk), .reset(reset), .req(z_req), .memWrite(z_we), .addr(z_addr),
    .writeData(z_wd), .readData(z_rd), .ready(z_ready), .err(z_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit z, input logic r, input logic w,
                       input logic [31:0] ad, input logic [31:0] wd);
    if (z) begin z_req = r; z_we = w; z_addr = ad; z_wd = wd; end
    else   begin a_req = r; a_we = w; a_addr = ad; a_wd = wd; end
  endtask

  // One access: accept edge, then count edges until ready (bounded).
  task automatic acc(input bit z, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    drive(z, 1'b1, w, ad, wd);
    step();
    drive(z, 1'b0, 1'b0, '0, '0);
    lat = 0;
    while (!(z ? z_ready : a_ready) && lat < 20) begin
      step();
      lat++;
    end
    rd = z ? z_rd : a_rd;
    er = z ? z_err : a_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          pulses;
  logic [31:0] bexp [4];

  initial begin
    // reset state
    step(); step();
    chk("rst_rd", a_rd, 32'h0);
    chk("rst_ready", {31'b0, a_ready}, 32'h0);
    chk("rst_err", {31'b0, a_err}, 32'h0);
    reset = 1'b1;
    step();

    // store then load, 2 wait states
    acc(0, 1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st_lat", 32'(lat), 32'd2);
    chk("st_rd_hold", rd, 32'h0);
    chk("st_err", {31'b0, er}, 32'h0);
    acc(0, 0, 32'h10, 32'h0, rd, er, lat);
    chk("ld_lat", 32'(lat), 32'd2);
    chk("ld_rd", rd, 32'hDEADBEEF);
    acc(0, 0, 32'h13, 32'h0, rd, er, lat);
    chk("ld_unaligned", rd, 32'hDEADBEEF);
    step();
    chk("ready_pulse", {31'b0, a_ready}, 32'h0);
    chk("rd_stable", a_rd, 32'hDEADBEEF);

    // back-to-back burst with req held high
    bexp[0] = 32'hA0000030; bexp[1] = 32'hA0000034; bexp[2] = 32'hA0000038; bexp[3] = 32'h0;
    for (int i = 0; i < 3; i++) acc(0, 1, 32'h30 + 32'(4 * i), bexp[i], rd, er, lat);
    pulses = 0;
    a_req = 1'b1; a_we = 1'b0;
    for (int c = 0; c < 9; c++) begin
      a_addr = 32'h30 + 32'(4 * (c / 3));
      step();
      if (a_ready) begin
        chk("burst_edge", 32'(c), 32'(3 * pulses + 2));
        chk("burst_data", a_rd, bexp[pulses < 3 ? pulses : 3]);
        pulses++;
      end
    end
    a_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (a_ready) pulses++;
    end
    chk("burst_pulses", 32'(pulses), 32'd3);

    // zero wait states
    acc(1, 1, 32'h04, 32'h44444444, rd, er, lat);
    acc(1, 1, 32'h08, 32'h88888888, rd, er, lat);
    acc(1, 0, 32'h04, 32'h0, rd, er, lat);
    chk("z_lat", 32'(lat), 32'd0);
    chk("z_rd", rd, 32'h44444444);
    drive(1, 1'b1, 1'b0, 32'h04, '0);
    step();
    chk("z_b2b_rdy0", {31'b0, z_ready}, 32'h1);
    chk("z_b2b_rd0", z_rd, 32'h44444444);
    z_addr = 32'h08;
    step();
    chk("z_b2b_rdy1", {31'b0, z_ready}, 32'h1);
    chk("z_b2b_rd1", z_rd, 32'h88888888);
    drive(1, 1'b0, 1'b0, '0, '0);
    step();
    chk("z_idle", {31'b0, z_ready}, 32'h0);

    // reset aborts a pending store
    acc(0, 1, 32'h20, 32'h11111111, rd, er, lat);
    acc(0, 0, 32'h20, 32'h0, rd, er, lat);
    chk("pre_abort_rd", rd, 32'h11111111);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    step();
    drive(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    #1;
    chk("abort_rd", a_rd, 32'h0);
    chk("abort_ready", {31'b0, a_ready}, 32'h0);
    step(); step();
    reset = 1'b1;
    step();
    acc(0, 0, 32'h20, 32'h0, rd, er, lat);
    chk("abort_nocommit", rd, 32'h11111111);

    // upper address bits
    acc(0, 1, 32'h000, 32'h77777777, rd, er, lat);
    acc(0, 1, 32'h0FC, 32'hFCFCFCFC, rd, er, lat);
    acc(0, 0, 32'h0FC, 32'h0, rd, er, lat);
    chk("last_word_rd", rd, 32'hFCFCFCFC);
    chk("last_word_err", {31'b0, er}, 32'h0);
    acc(0, 1, 32'h100, 32'hA5A5A5A5, rd, er, lat);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("oob_st_err", {31'b0, er}, 32'h1);
    acc(0, 0, 32'h100, 32'h0, rd, er, lat);
    chk("oob_ld_rd", rd, 32'h0);
    chk("oob_ld_err", {31'b0, er}, 32'h1);
    acc(0, 0, 32'h000, 32'h0, rd, er, lat);
    chk("oob_nowrite", rd, 32'h77777777);
    chk("inrange_err", {31'b0, er}, 32'h0);
`else
    chk("wrap_st_err", {31'b0, er}, 32'h0);
    acc(0, 0, 32'h000, 32'h0, rd, er, lat);
    chk("wrap_rd", rd, 32'hA5A5A5A5);
    chk("wrap_err", {31'b0, er}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
